mult_issue_queue: RTL and testbench

Flow-control stage wrapped around the fixed-latency `multiplier`. The multiplier has no valid, ready or stall signals, so this block supplies them. It accepts tagged operand pairs over a valid/ready handshake, buffers them, and issues at most one pair per cycle to the multiplier. It tracks in-flight operations with a valid/tag shift register matched to the multiplier latency and captures products into an output FIFO. Issue is credit-gated so a result is never lost under downstream backpressure.

---
 rtl/mult_pkg.sv | 15 +
 rtl/sync_fifo.sv | 37 +++
 rtl/mult_issue_queue.sv | 77 +++++++
 tb/tb_mult_issue_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared request/response types and defaults for the multiplier issue queue.
package mult_pkg;
  localparam int MULT_LATENCY_DEFAULT = 3;
  localparam int MULT_DATA_LEN = 32;
  localparam int MULT_TAG_LEN = 8;
  typedef struct packed {
    logic [MULT_DATA_LEN-1:0] a;
    logic [MULT_DATA_LEN-1:0] b;
    logic [MULT_TAG_LEN-1:0]  tag;
  } mult_req_t;
  typedef struct packed {
    logic [MULT_DATA_LEN-1:0] result;
    logic [MULT_TAG_LEN-1:0]  tag;
  } mult_rsp_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/mult_issue_queue.sv
// mult_issue_queue: valid/ready flow control, in-flight tracking and result
// buffering around an external fixed-latency multiplier.
module mult_issue_queue
  import mult_pkg::*;
#(
  parameter int DATA_LEN = MULT_DATA_LEN,
  parameter int TAG_LEN = MULT_TAG_LEN,
  parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  input  logic [TAG_LEN-1:0]  in_tag,
  output logic [DATA_LEN-1:0] mul_a,
  output logic [DATA_LEN-1:0] mul_b,
  input  logic [DATA_LEN-1:0] mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_result,
  output logic [TAG_LEN-1:0]  out_tag,
  output logic                busy
);
  localparam int IW = $clog2(MULT_LATENCY + 2);
  localparam int CW = $clog2(OUT_DEPTH + MULT_LATENCY + 2);
  mult_req_t in_req, head;
  mult_rsp_t rsp, out_head;
  logic in_full, in_empty, out_full, out_empty, issue, capture;
  logic [$clog2(IN_DEPTH):0] in_count;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic [IW-1:0] inflight;
  logic [MULT_LATENCY:0] sr_v;
  logic [TAG_LEN-1:0] sr_tag [MULT_LATENCY+1];
  assign in_req = '{a: in_a, b: in_b, tag: in_tag};
  assign in_ready = !in_full && !reset;
  // every result already buffered or still in the pipe holds an output slot
  assign issue = !in_empty && (CW'(out_count) + CW'(inflight) < CW'(OUT_DEPTH));
  assign capture = sr_v[MULT_LATENCY];
  assign rsp = '{result: mul_result, tag: sr_tag[MULT_LATENCY]};
  assign out_valid = !out_empty;
  assign out_result = out_head.result;
  assign out_tag = out_head.tag;
  assign busy = in_count != '0 || !out_empty || inflight != '0;
  sync_fifo #(.WIDTH($bits(mult_req_t)), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .push(in_valid && in_ready), .wdata(in_req),
    .pop(issue), .rdata(head), .count(in_count), .full(in_full), .empty(in_empty)
  );
  sync_fifo #(.WIDTH($bits(mult_rsp_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .push(capture), .wdata(rsp),
    .pop(out_ready), .rdata(out_head), .count(out_count), .full(out_full), .empty(out_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_v <= '0;
      inflight <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      sr_v <= {sr_v[MULT_LATENCY-1:0], issue};
      inflight <= inflight + IW'(issue) - IW'(capture);
      if (issue) begin
        mul_a <= head.a;
        mul_b <= head.b;
      end
    end
  end
  // tags need no reset: they are only consumed when the matching valid bit is set
  always_ff @(posedge clk) begin
    sr_tag[0] <= head.tag;
    for (int i = 1; i <= MULT_LATENCY; i++) sr_tag[i] <= sr_tag[i-1];
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(capture && out_full));
endmodule

// File: tb/tb_mult_issue_queue.sv
// tb_mult_issue_queue: table vectors, hand sequences and random traffic checked
// against a queue-based reference of accepted operations.
module tb_mult_issue_queue;
  localparam int DL = 32;
  localparam int TL = 8;
  localparam int LAT = 3;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy, hs;
  logic [DL-1:0] in_a = '0, in_b = '0, mul_a, mul_b, mul_result, out_result;
  logic [TL-1:0] in_tag = '0, out_tag;
  logic [DL-1:0] mp [LAT];
  int n_checks = 0, n_fail = 0, cyc = 0, acc_cnt = 0, out_cnt = 0;
  int lat, base, obase, gaps, idx, bad;
  logic got;
  typedef struct {logic [DL-1:0] r; logic [TL-1:0] t;} exp_t;
  typedef struct {logic [DL-1:0] a; logic [DL-1:0] b; logic [TL-1:0] tag; logic [DL-1:0] r;} vec_t;
  exp_t exp_q[$];
  exp_t mon_e, mon_n;
  int out_cyc[$];
  vec_t vt[6];
  logic [DL-1:0] ba[20], bb[20];

  mult_issue_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the external multiplier: LAT register stages after mul_a/mul_b
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < LAT; i++) mp[i] <= '0;
    else begin
      mp[0] <= DL'(mul_a * mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_result = mp[LAT-1];

  function automatic logic [DL-1:0] ref_mul(input logic [DL-1:0] a, input logic [DL-1:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return p[DL-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every accepted pair must come out once, in order, with its product
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (in_valid && in_ready) begin
        mon_n.r = ref_mul(in_a, in_b);
        mon_n.t = in_tag;
        exp_q.push_back(mon_n);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("spurious output", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("sb result", out_result, mon_e.r);
          chk("sb tag", out_tag, mon_e.t);
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic drive(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic [TL-1:0] t);
    in_a = a; in_b = b; in_tag = t; in_valid = 1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (k == 50) chk("accept timeout", 0, 1);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // cycle index (accept edge ends cycle 0) at which out_valid is first seen
  task automatic wait_out(output int n);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
  endtask

  task automatic set_bp(input int i);
    in_a = ba[i]; in_b = bb[i]; in_tag = TL'(i + 64);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'd7, 32'hFFFFFFFD, 8'd5, 32'hFFFFFFEB};
    vt[1] = '{32'h7FFFFFFF, 32'd2, 8'd6, 32'hFFFFFFFE};
    vt[2] = '{32'h80000000, 32'hFFFFFFFF, 8'd7, 32'h80000000};
    vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 32'd1};
    vt[4] = '{32'h00010000, 32'h00010000, 8'h00, 32'd0};
    vt[5] = '{32'd0, 32'h12345678, 8'hA5, 32'd0};
    for (int i = 0; i < 20; i++) begin ba[i] = $urandom; bb[i] = $urandom; end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset mul_a", mul_a, 0);
    chk("reset mul_b", mul_b, 0);
    chk("reset out_result", out_result, 0);
    chk("reset out_tag", out_tag, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    // single operations, exact latency
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].tag);
      wait_out(lat);
      chk("vec latency", lat, 6);
      chk("vec result", out_result, vt[i].r);
      chk("vec tag", out_tag, vt[i].tag);
      @(posedge clk); #1;
      chk("vec idle busy", busy, 0);
    end

    // streaming: one result per cycle
    base = out_cnt;
    out_cyc.delete();
    for (int i = 0; i < 16; i++) drive(DL'(i), DL'(i + 1), TL'(i));
    for (int t = 0; t < 50 && out_cnt - base < 16; t++) begin @(posedge clk); #1; end
    chk("stream count", out_cnt - base, 16);
    gaps = 0;
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) gaps++;
    chk("stream gaps", gaps, 0);

    // backpressure: capacity, then drain in order
    out_ready = 0;
    base = acc_cnt;
    obase = out_cnt;
    idx = 0;
    set_bp(0);
    in_valid = 1;
    while (idx < 20) begin
      got = 0;
      for (int k = 0; k < 30; k++) begin @(negedge clk); if (in_ready) begin got = 1; break; end end
      if (!got) break;
      @(posedge clk); #1;
      idx++;
      if (idx < 20) set_bp(idx);
    end
    chk("bp accepted", acc_cnt - base, 12);
    chk("bp in_ready low", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp pop no same-cycle credit", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full fifo issue blocks write", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready after issue", in_ready, 1);
    @(posedge clk); #1;
    idx++;
    if (idx < 20) set_bp(idx);
    while (idx < 20) begin
      got = 0;
      for (int k = 0; k < 30; k++) begin @(negedge clk); if (in_ready) begin got = 1; break; end end
      if (!got) begin chk("bp resume timeout", 0, 1); break; end
      @(posedge clk); #1;
      idx++;
      if (idx < 20) set_bp(idx);
    end
    in_valid = 0;
    for (int t = 0; t < 100 && out_cnt - obase < 20; t++) begin @(posedge clk); #1; end
    chk("bp delivered", out_cnt - obase, 20);
    chk("bp none left", exp_q.size(), 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs || !in_valid) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        in_b = $urandom;
        in_tag = TL'($urandom);
      end
      out_ready = $urandom_range(0, 2) != 0;
    end
    in_valid = 0;
    out_ready = 1;
    for (int t = 0; t < 100 && busy; t++) begin @(posedge clk); #1; end
    chk("random drained busy", busy, 0);
    chk("random none left", exp_q.size(), 0);

    // reset with operations in flight and queued
    for (int i = 0; i < 5; i++) drive($urandom, $urandom, TL'(200 + i));
    reset = 1;
    @(negedge clk);
    chk("in_ready during reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset busy", busy, 0);
    bad = 0;
    repeat (10) begin @(negedge clk); if (out_valid) bad++; end
    chk("no stale output", bad, 0);
    @(posedge clk); #1;
    drive(32'd12, 32'hFFFFFFFE, 8'd9);
    wait_out(lat);
    chk("post reset latency", lat, 6);
    chk("post reset result", out_result, 32'hFFFFFFE8);
    chk("post reset tag", out_tag, 8'd9);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
